wb_stage_skid_reg: RTL and testbench

- Parametrised successor of the MEM->WB pipeline register.
- Carries WB_EN, Mem_R_EN, dest, ALU result and memory data from the memory stage to write-back.
- Adds a valid/ready handshake, a 2-entry skid buffer so back-pressure never drops an instruction, and a synchronous flush.
- Widths are generic, so the same block serves the cached/stalling memory path.

---
 rtl/wb_stage_skid_reg.sv | 170 +++++++++++++++++
 tb/tb_wb_stage_skid_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_skid_reg.sv
// MEM->WB pipeline register with a valid/ready handshake and a two-entry skid buffer.
// Define WB_STAGE_RESULT_MUX_EN to add the wb_value output.
module wb_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN_in,
  input  logic              Mem_R_EN_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [DATA_W-1:0] ALU_res_in,
  input  logic [DATA_W-1:0] Mem_Data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_EN,
  output logic              Mem_R_EN,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] ALU_res,
`ifdef WB_STAGE_RESULT_MUX_EN
  output logic [DATA_W-1:0] wb_value,
`endif
  output logic [DATA_W-1:0] Mem_Data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                wb_en_q, wb_en_d;
  logic                mem_r_en_q, mem_r_en_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   mem_q, mem_d;
  logic                sk_wb_en_q, sk_wb_en_d;
  logic                sk_mem_r_en_q, sk_mem_r_en_d;
  logic [DEST_W-1:0]   sk_dest_q, sk_dest_d;
  logic [DATA_W-1:0]   sk_alu_q, sk_alu_d;
  logic [DATA_W-1:0]   sk_mem_q, sk_mem_d;

  logic accept;
  logic consume;

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  always_comb begin
    state_d       = state_q;
    wb_en_d       = wb_en_q;
    mem_r_en_d    = mem_r_en_q;
    dest_d        = dest_q;
    alu_d         = alu_q;
    mem_d         = mem_q;
    sk_wb_en_d    = sk_wb_en_q;
    sk_mem_r_en_d = sk_mem_r_en_q;
    sk_dest_d     = sk_dest_q;
    sk_alu_d      = sk_alu_q;
    sk_mem_d      = sk_mem_q;

    // Flush keeps the output data fields untouched; only validity is dropped.
    if (flush) begin
      state_d       = EMPTY;
      sk_wb_en_d    = 1'b0;
      sk_mem_r_en_d = 1'b0;
      sk_dest_d     = '0;
      sk_alu_d      = '0;
      sk_mem_d      = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = ONE;
            wb_en_d    = WB_EN_in;
            mem_r_en_d = Mem_R_EN_in;
            dest_d     = dest_in;
            alu_d      = ALU_res_in;
            mem_d      = Mem_Data_in;
          end
        end
        ONE: begin
          if (accept && consume) begin
            wb_en_d    = WB_EN_in;
            mem_r_en_d = Mem_R_EN_in;
            dest_d     = dest_in;
            alu_d      = ALU_res_in;
            mem_d      = Mem_Data_in;
          end else if (accept) begin
            state_d       = FULL;
            sk_wb_en_d    = WB_EN_in;
            sk_mem_r_en_d = Mem_R_EN_in;
            sk_dest_d     = dest_in;
            sk_alu_d      = ALU_res_in;
            sk_mem_d      = Mem_Data_in;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_d       = ONE;
            wb_en_d       = sk_wb_en_q;
            mem_r_en_d    = sk_mem_r_en_q;
            dest_d        = sk_dest_q;
            alu_d         = sk_alu_q;
            mem_d         = sk_mem_q;
            sk_wb_en_d    = 1'b0;
            sk_mem_r_en_d = 1'b0;
            sk_dest_d     = '0;
            sk_alu_d      = '0;
            sk_mem_d      = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
    if (state_d == EMPTY) wb_en_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      wb_en_q       <= 1'b0;
      mem_r_en_q    <= 1'b0;
      dest_q        <= '0;
      alu_q         <= '0;
      mem_q         <= '0;
      sk_wb_en_q    <= 1'b0;
      sk_mem_r_en_q <= 1'b0;
      sk_dest_q     <= '0;
      sk_alu_q      <= '0;
      sk_mem_q      <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      wb_en_q       <= wb_en_d;
      mem_r_en_q    <= mem_r_en_d;
      dest_q        <= dest_d;
      alu_q         <= alu_d;
      mem_q         <= mem_d;
      sk_wb_en_q    <= sk_wb_en_d;
      sk_mem_r_en_q <= sk_mem_r_en_d;
      sk_dest_q     <= sk_dest_d;
      sk_alu_q      <= sk_alu_d;
      sk_mem_q      <= sk_mem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign WB_EN     = wb_en_q;
  assign Mem_R_EN  = mem_r_en_q;
  assign dest      = dest_q;
  assign ALU_res   = alu_q;
  assign Mem_Data  = mem_q;

`ifdef WB_STAGE_RESULT_MUX_EN
  assign wb_value = mem_r_en_q ? mem_q : alu_q;
`endif

endmodule

// File: tb/tb_wb_stage_skid_reg.sv
// Directed bench for wb_stage_skid_reg: vector table plus stall, reset and result-mux sequences.
module tb_wb_stage_skid_reg;
  localparam int DATA_W = 32;
  localparam int DEST_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              WB_EN_in;
  logic              Mem_R_EN_in;
  logic [DEST_W-1:0] dest_in;
  logic [DATA_W-1:0] ALU_res_in;
  logic [DATA_W-1:0] Mem_Data_in;
  logic              out_valid;
  logic              out_ready;
  logic              WB_EN;
  logic              Mem_R_EN;
  logic [DEST_W-1:0] dest;
  logic [DATA_W-1:0] ALU_res;
  logic [DATA_W-1:0] Mem_Data;
`ifdef WB_STAGE_RESULT_MUX_EN
  logic [DATA_W-1:0] wb_value;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_skid_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_EN_in(WB_EN_in), .Mem_R_EN_in(Mem_R_EN_in), .dest_in(dest_in),
    .ALU_res_in(ALU_res_in), .Mem_Data_in(Mem_Data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_EN(WB_EN), .Mem_R_EN(Mem_R_EN), .dest(dest), .ALU_res(ALU_res),
`ifdef WB_STAGE_RESULT_MUX_EN
    .wb_value(wb_value),
`endif
    .Mem_Data(Mem_Data)
  );

  typedef struct {
    logic        flush;
    logic        iv;
    logic        wb;
    logic        mr;
    logic [3:0]  dst;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic        e_wb;
    logic        e_mr;
    logic [3:0]  e_dst;
    logic [31:0] e_alu;
    logic [31:0] e_mem;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic wb, input logic mr,
                       input logic [3:0] dst, input logic [31:0] alu, input logic [31:0] mem,
                       input logic ordy);
    flush = fl; in_valid = iv; WB_EN_in = wb; Mem_R_EN_in = mr;
    dest_in = dst; ALU_res_in = alu; Mem_Data_in = mem; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //           fl iv wb mr dst   alu           mem           ordy ov ir wb mr dst   alu           mem
    vecs[0]  = '{0, 1, 1, 0, 4'h3, 32'h0000_1234, 32'h0,        1,   1, 1, 1, 0, 4'h3, 32'h0000_1234, 32'h0};
    vecs[1]  = '{0, 0, 0, 0, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  0, 1, 0, 0, 4'h3, 32'h0000_1234, 32'h0};
    vecs[2]  = '{0, 1, 1, 0, 4'h1, 32'hA1,        32'h0,        0,   1, 1, 1, 0, 4'h1, 32'hA1,        32'h0};
    vecs[3]  = '{0, 1, 0, 1, 4'h2, 32'hB2,        32'hB0B0,     0,   1, 0, 1, 0, 4'h1, 32'hA1,        32'h0};
    vecs[4]  = '{0, 1, 1, 1, 4'h9, 32'h99,        32'h9999,     0,   1, 0, 1, 0, 4'h1, 32'hA1,        32'h0};
    vecs[5]  = '{0, 0, 0, 0, 4'h0, 32'h0,         32'h0,        1,   1, 1, 0, 1, 4'h2, 32'hB2,        32'hB0B0};
    vecs[6]  = '{0, 1, 1, 1, 4'h5, 32'h55,        32'h5555,     1,   1, 1, 1, 1, 4'h5, 32'h55,        32'h5555};
    vecs[7]  = '{0, 1, 1, 0, 4'h6, 32'h66,        32'h6666,     0,   1, 0, 1, 1, 4'h5, 32'h55,        32'h5555};
    vecs[8]  = '{1, 1, 1, 0, 4'h7, 32'h77,        32'h7777,     0,   0, 1, 0, 1, 4'h5, 32'h55,        32'h5555};
    vecs[9]  = '{0, 0, 0, 0, 4'h0, 32'h0,         32'h0,        1,   0, 1, 0, 1, 4'h5, 32'h55,        32'h5555};
    vecs[10] = '{0, 1, 0, 0, 4'h8, 32'h80,        32'h8080,     1,   1, 1, 0, 0, 4'h8, 32'h80,        32'h8080};
    vecs[11] = '{1, 0, 0, 0, 4'h0, 32'h0,         32'h0,        1,   0, 1, 0, 0, 4'h8, 32'h80,        32'h8080};

    rst = 1'b1;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    #12;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset in_ready",  {31'b0, in_ready},  32'd1);
    check("reset WB_EN",     {31'b0, WB_EN},     32'd0);
    check("reset dest",      {28'b0, dest},      32'd0);
    check("reset ALU_res",   ALU_res,            32'd0);
    check("reset Mem_Data",  Mem_Data,           32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].iv, vecs[i].wb, vecs[i].mr, vecs[i].dst,
            vecs[i].alu, vecs[i].mem, vecs[i].ordy);
      step();
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      check($sformatf("v%0d in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].e_ir});
      check($sformatf("v%0d WB_EN", i),     {31'b0, WB_EN},     {31'b0, vecs[i].e_wb});
      check($sformatf("v%0d Mem_R_EN", i),  {31'b0, Mem_R_EN},  {31'b0, vecs[i].e_mr});
      check($sformatf("v%0d dest", i),      {28'b0, dest},      {28'b0, vecs[i].e_dst});
      check($sformatf("v%0d ALU_res", i),   ALU_res,            vecs[i].e_alu);
      check($sformatf("v%0d Mem_Data", i),  Mem_Data,           vecs[i].e_mem);
    end

    // Stall hold: entry A held for five cycles while in_valid toggles; B enters skid, C/D rejected.
    do_reset();
    drive(0, 1, 1, 0, 4'hA, 32'hAAAA, 32'h1, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c % 2 == 0) drive(0, 1, 0, 1, 4'(4'hB + c), 32'(32'hB000 + c), 32'h2, 0);
      else            drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
      step();
      check($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 32'd1);
      check($sformatf("stall%0d WB_EN", c),     {31'b0, WB_EN},     32'd1);
      check($sformatf("stall%0d dest", c),      {28'b0, dest},      32'hA);
      check($sformatf("stall%0d ALU_res", c),   ALU_res,            32'hAAAA);
      check($sformatf("stall%0d Mem_Data", c),  Mem_Data,           32'h1);
      check($sformatf("stall%0d in_ready", c),  {31'b0, in_ready},  32'd0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    step();
    check("drain1 out_valid", {31'b0, out_valid}, 32'd1);
    check("drain1 dest",      {28'b0, dest},      32'hB);
    check("drain1 ALU_res",   ALU_res,            32'hB000);
    check("drain1 Mem_R_EN",  {31'b0, Mem_R_EN},  32'd1);
    check("drain1 in_ready",  {31'b0, in_ready},  32'd1);
    step();
    check("drain2 out_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while FULL, checked before the next rising edge.
    @(negedge clk);
    drive(0, 1, 1, 1, 4'hC, 32'hC0, 32'hCC, 0);
    step();
    @(negedge clk);
    drive(0, 1, 1, 1, 4'hD, 32'hD0, 32'hDD, 0);
    step();
    check("pre-rst in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst out_valid", {31'b0, out_valid}, 32'd0);
    check("arst WB_EN",     {31'b0, WB_EN},     32'd0);
    check("arst Mem_R_EN",  {31'b0, Mem_R_EN},  32'd0);
    check("arst dest",      {28'b0, dest},      32'd0);
    check("arst ALU_res",   ALU_res,            32'd0);
    check("arst Mem_Data",  Mem_Data,           32'd0);
    check("arst in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    step();
    check("post-rst out_valid", {31'b0, out_valid}, 32'd0);

`ifdef WB_STAGE_RESULT_MUX_EN
    check("mux reset", wb_value, 32'd0);
    @(negedge clk);
    drive(0, 1, 1, 1, 4'h4, 32'h10, 32'hDEAD_BEEF, 1);
    step();
    check("mux load", wb_value, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(0, 1, 1, 0, 4'h5, 32'h55, 32'h1234_5678, 1);
    step();
    check("mux alu", wb_value, 32'h55);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
